multi_alarm_clock: RTL and testbench
====================================

MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: clk cycles per second tick.
REQ-002 SHALL have parameter NUM_ALARMS, default 4, legal range 1..7: number of alarm channels.
REQ-003 SHALL have parameter RING_S, default 60, legal range 1..255: maximum ring duration in second ticks.
REQ-004 SHALL have port clk, input, 1: the single clock for all logic.
REQ-005 SHALL have port rst, input, 1: reset, synchronous to clk and active-high.
REQ-006 SHALL have port inc_pulse, input, 1: debounced single-cycle request to increment the selected field.
REQ-007 SHALL have port field_sel, input, 2: selected field, 00 run, 01 hour, 10 minute, 11 second.
REQ-008 SHALL have port target, input, 3: 0 selects the time of day; k in 1..NUM_ALARMS selects alarm k-1; other values select nothing.
REQ-009 SHALL have port alarm_en, input, NUM_ALARMS: per-channel alarm enable.
REQ-010 SHALL have port alarm_ack, input, 1: single-cycle request to stop ringing.
REQ-011 SHALL have ports hour, minute and second, output, 8 each: time of day as two-digit BCD.
REQ-012 SHALL have ports disp_hour, disp_minute and disp_second, output, 8 each: BCD view of the selected target; for an alarm, disp_second = 8'h00; for an invalid target, all three = 8'h00.
REQ-013 SHALL have port sec_tick, output, 1: single-cycle pulse once per second.
REQ-014 SHALL have port ring, output, 1: alarm is active.
REQ-015 SHALL have port ring_id, output, 3: index of the alarm that is ringing.

Function
REQ-016 SHALL use a divider that counts 0..CLK_HZ-1 and asserts sec_tick in the cycle the count equals CLK_HZ-1, wrapping to 0 in the next cycle.
REQ-017 SHALL, when sec_tick is asserted, target != 0 or field_sel = 00, advance time by one second with carry sec 59->00 into minute, minute 59->00 into hour, hour 23->00.
REQ-018 SHALL treat 23:59:59 followed by a counted tick as 00:00:00.
REQ-019 SHALL drop ticks while target = 0 and field_sel != 00 (time frozen); the divider SHALL keep running.
REQ-020 SHALL make the outputs reflect the new time on the cycle after sec_tick.
REQ-021 SHALL, on inc_pulse, increment only the selected field of the selected target, modulo 24/60/60, with no carry into other fields.
REQ-022 SHALL, when inc_pulse coincides with a counted tick, let the increment take precedence and drop that tick.
REQ-023 SHALL ignore inc_pulse when field_sel = 00, when target is invalid, or when field_sel = 11 and target != 0.
REQ-024 SHALL keep every BCD digit legal at all times: low digit 0-9; high digit 0-2 for hour and 0-5 for minute and second.
REQ-025 SHALL store hour and minute only for each alarm.
REQ-026 SHALL implement a ring FSM with states IDLE and RING.
REQ-027 SHALL, in IDLE, move to RING on the first cycle the time equals hh:mm:00 after a counted tick, for any channel k with alarm_en[k]=1 and alarm k = hh:mm.
REQ-028 SHALL, in that transition, load ring_id = lowest matching k and load the ring counter = RING_S.
REQ-029 SHALL, in RING, decrement the ring counter on each sec_tick and return to IDLE when it reaches 0.
REQ-030 SHALL, in RING, return to IDLE on alarm_ack or when alarm_en[ring_id] falls.
REQ-031 SHALL ignore new matches while in RING; a match that coincides with alarm_ack SHALL be lost.
REQ-032 SHALL have ring = 1 exactly in RING; ring_id SHALL hold its value in IDLE.
REQ-033 SHALL ignore alarm_ack in IDLE.

Reset
REQ-034 SHALL, on rst high at a clk edge, set: divider 0; time 00:00:00; all alarms 00:00; FSM IDLE; ring counter 0.
REQ-035 SHALL hold all outputs at 0 during reset (hour, minute, second, disp_*, sec_tick, ring, ring_id).
REQ-036 SHALL give rst priority over every other input, including mid-ring and mid-setting.
REQ-037 SHALL produce the first sec_tick CLK_HZ cycles after rst falls.

Structure
REQ-038 SHALL place in shared package clock_pkg: field_sel encodings, ring FSM state enum, and BCD limit constants (23, 59).
REQ-039 SHALL implement each two-digit BCD field as sub-module bcd_mod_counter, parametrised by maximum value, with ports inc and carry_out; the time uses three instances.
REQ-040 SHALL store alarm registers as an array sized NUM_ALARMS; the compare SHALL be a priority encoder, not separate instances.

Verification (CLK_HZ = 4, NUM_ALARMS = 4, RING_S = 3)
REQ-041 SHALL cover rollover: set 23:59:58, run 2 ticks -> second tick yields 00:00:00; sec_tick period 4 cycles.
REQ-042 SHALL cover setting: target = 0, field_sel = 10 at 10:59:30, 3 inc_pulse over 40 cycles -> 10:02:30, hour unchanged, no ticks counted.
REQ-043 SHALL cover priority: alarms 1 and 2 = 07:00, both enabled, time 06:59:59 -> after tick ring = 1, ring_id = 1; ring = 0 after 3 further ticks.
REQ-044 SHALL cover ack and disable: ring active, alarm_ack pulse -> ring = 0 next cycle; repeat with alarm_en[ring_id] dropped -> same result.
REQ-045 SHALL cover reset mid-ring: rst asserted while ring = 1 -> next cycle all outputs 0 and FSM IDLE; an alarm-1 view shows 00:00:00.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared encodings, ring FSM states and BCD helpers for the multi-alarm clock.
package clock_pkg;

    typedef enum logic [1:0] {
        FS_RUN  = 2'b00,
        FS_HOUR = 2'b01,
        FS_MIN  = 2'b10,
        FS_SEC  = 2'b11
    } field_sel_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RING = 1'b1
    } ring_state_e;

    localparam logic [7:0] BCD_MAX_HOUR    = 8'h23;
    localparam logic [7:0] BCD_MAX_MIN_SEC = 8'h59;

    // Next two-digit BCD value, wrapping to 00 past max_val; out-of-range input also wraps.
    function automatic logic [7:0] bcd_next(input logic [7:0] val, input logic [7:0] max_val);
        logic [7:0] res;
        if (val >= max_val) begin
            res = 8'h00;
        end else if (val[3:0] >= 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps after MAX_VAL and flags the wrap on carry_out.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX_VAL = BCD_MAX_MIN_SEC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] value,
    output logic       carry_out
);

    logic [7:0] value_r;

    // Field register.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= 8'h00;
        end else if (inc) begin
            value_r <= bcd_next(value_r, MAX_VAL);
        end else begin
            value_r <= value_r;
        end
    end

    assign value     = value_r;
    assign carry_out = inc && (value_r == MAX_VAL);

endmodule

// File: rtl/multi_alarm_clock.sv
// Time-of-day clock with NUM_ALARMS settable hh:mm alarms and a single ring channel.
module multi_alarm_clock
    import clock_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int NUM_ALARMS = 4,
    parameter int RING_S     = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_pulse,
    input  logic [1:0]            field_sel,
    input  logic [2:0]            target,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  alarm_ack,
    output logic [7:0]            hour,
    output logic [7:0]            minute,
    output logic [7:0]            second,
    output logic [7:0]            disp_hour,
    output logic [7:0]            disp_minute,
    output logic [7:0]            disp_second,
    output logic                  sec_tick,
    output logic                  ring,
    output logic [2:0]            ring_id
);

    localparam int               DIV_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_next_s;
    logic             sec_tick_r;
    logic             time_sel_s;
    logic             alarm_sel_s;
    logic             count_en_s;
    logic             set_ok_s;
    logic             sec_inc_s;
    logic             min_inc_s;
    logic             hour_inc_s;
    logic             sec_carry_s;
    logic             min_carry_s;
    logic             hour_carry_unused_s;
    logic [7:0]       hour_s;
    logic [7:0]       minute_s;
    logic [7:0]       second_s;
    logic [7:0]       alarm_hour_r [NUM_ALARMS];
    logic [7:0]       alarm_min_r  [NUM_ALARMS];
    logic             tick_d_r;
    logic             match_any_s;
    logic [2:0]       match_id_s;
    logic             ring_en_s;
    ring_state_e      state_r;
    ring_state_e      state_s;
    logic [7:0]       ring_cnt_r;
    logic [7:0]       ring_cnt_s;
    logic [2:0]       ring_id_r;
    logic [2:0]       ring_id_s;
    logic [7:0]       disp_hour_s;
    logic [7:0]       disp_minute_s;
    logic [7:0]       disp_second_s;

    // Divider next value; sec_tick is registered so it is high while div_r holds DIV_LAST.
    always_comb begin
        div_next_s = (div_r == DIV_LAST) ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
    end

    // Second divider and tick flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r      <= {DIV_W{1'b0}};
            sec_tick_r <= 1'b0;
        end else begin
            div_r      <= div_next_s;
            sec_tick_r <= (div_next_s == DIV_LAST);
        end
    end

    // Target decode, tick gating and set qualification.
    always_comb begin
        time_sel_s  = (target == 3'd0);
        alarm_sel_s = 1'b0;
        for (int k = 0; k < NUM_ALARMS; k++) begin
            alarm_sel_s = alarm_sel_s | (target == 3'(k + 1));
        end
        count_en_s = sec_tick_r && !(time_sel_s && (field_sel != FS_RUN));
        set_ok_s   = inc_pulse && (field_sel != FS_RUN)
                     && (time_sel_s || (alarm_sel_s && (field_sel != FS_SEC)));
        // Setting the time freezes it, so a set and a counted tick never meet here.
        sec_inc_s  = count_en_s || (set_ok_s && time_sel_s && (field_sel == FS_SEC));
        min_inc_s  = (count_en_s && sec_carry_s) || (set_ok_s && time_sel_s && (field_sel == FS_MIN));
        hour_inc_s = (count_en_s && min_carry_s) || (set_ok_s && time_sel_s && (field_sel == FS_HOUR));
    end

    bcd_mod_counter #(.MAX_VAL(BCD_MAX_MIN_SEC)) u_sec (
        .clk       (clk),
        .rst       (rst),
        .inc       (sec_inc_s),
        .value     (second_s),
        .carry_out (sec_carry_s)
    );

    bcd_mod_counter #(.MAX_VAL(BCD_MAX_MIN_SEC)) u_min (
        .clk       (clk),
        .rst       (rst),
        .inc       (min_inc_s),
        .value     (minute_s),
        .carry_out (min_carry_s)
    );

    bcd_mod_counter #(.MAX_VAL(BCD_MAX_HOUR)) u_hour (
        .clk       (clk),
        .rst       (rst),
        .inc       (hour_inc_s),
        .value     (hour_s),
        .carry_out (hour_carry_unused_s)
    );

    // Alarm hh:mm storage, incremented one field at a time without carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
                alarm_hour_r[k] <= 8'h00;
                alarm_min_r[k]  <= 8'h00;
            end
        end else begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (set_ok_s && (target == 3'(k + 1)) && (field_sel == FS_HOUR)) begin
                    alarm_hour_r[k] <= bcd_next(alarm_hour_r[k], BCD_MAX_HOUR);
                end else begin
                    alarm_hour_r[k] <= alarm_hour_r[k];
                end
                if (set_ok_s && (target == 3'(k + 1)) && (field_sel == FS_MIN)) begin
                    alarm_min_r[k] <= bcd_next(alarm_min_r[k], BCD_MAX_MIN_SEC);
                end else begin
                    alarm_min_r[k] <= alarm_min_r[k];
                end
            end
        end
    end

    // Priority encoder over enabled alarms; descending scan lets the lowest index win.
    always_comb begin
        match_any_s = 1'b0;
        match_id_s  = 3'd0;
        ring_en_s   = 1'b0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (tick_d_r && (second_s == 8'h00) && alarm_en[k]
                && (alarm_hour_r[k] == hour_s) && (alarm_min_r[k] == minute_s)) begin
                match_any_s = 1'b1;
                match_id_s  = 3'(k);
            end else begin
                match_any_s = match_any_s;
                match_id_s  = match_id_s;
            end
            ring_en_s = ring_en_s | (alarm_en[k] && (ring_id_r == 3'(k)));
        end
    end

    // Ring FSM next state and counter.
    always_comb begin
        state_s    = state_r;
        ring_cnt_s = ring_cnt_r;
        ring_id_s  = ring_id_r;
        case (state_r)
            ST_IDLE: begin
                if (match_any_s) begin
                    state_s    = ST_RING;
                    ring_id_s  = match_id_s;
                    ring_cnt_s = 8'(RING_S);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RING: begin
                if (alarm_ack || !ring_en_s) begin
                    state_s    = ST_IDLE;
                    ring_cnt_s = 8'd0;
                end else if (sec_tick_r) begin
                    if (ring_cnt_r <= 8'd1) begin
                        state_s    = ST_IDLE;
                        ring_cnt_s = 8'd0;
                    end else begin
                        ring_cnt_s = ring_cnt_r - 8'd1;
                    end
                end else begin
                    state_s = ST_RING;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                ring_cnt_s = 8'd0;
            end
        endcase
    end

    // Ring FSM registers; tick_d_r marks the cycle right after a counted tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ring_cnt_r <= 8'd0;
            ring_id_r  <= 3'd0;
            tick_d_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            ring_cnt_r <= ring_cnt_s;
            ring_id_r  <= ring_id_s;
            tick_d_r   <= count_en_s;
        end
    end

    // Display view of the selected target, muxed from registered state.
    always_comb begin
        disp_hour_s   = 8'h00;
        disp_minute_s = 8'h00;
        disp_second_s = 8'h00;
        if (time_sel_s) begin
            disp_hour_s   = hour_s;
            disp_minute_s = minute_s;
            disp_second_s = second_s;
        end else begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (target == 3'(k + 1)) begin
                    disp_hour_s   = alarm_hour_r[k];
                    disp_minute_s = alarm_min_r[k];
                end else begin
                    disp_hour_s   = disp_hour_s;
                    disp_minute_s = disp_minute_s;
                end
            end
        end
    end

    assign hour        = hour_s;
    assign minute      = minute_s;
    assign second      = second_s;
    assign disp_hour   = disp_hour_s;
    assign disp_minute = disp_minute_s;
    assign disp_second = disp_second_s;
    assign sec_tick    = sec_tick_r;
    assign ring        = (state_r == ST_RING);
    assign ring_id     = ring_id_r;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scoreboard bench for multi_alarm_clock with a 4-cycle second and a 3-second ring.
module tb_multi_alarm_clock;

    localparam int CLK_HZ     = 4;
    localparam int NUM_ALARMS = 4;
    localparam int RING_S     = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  inc_pulse;
    logic [1:0]            field_sel;
    logic [2:0]            target;
    logic [NUM_ALARMS-1:0] alarm_en;
    logic                  alarm_ack;
    logic [7:0]            hour, minute, second;
    logic [7:0]            disp_hour, disp_minute, disp_second;
    logic                  sec_tick, ring;
    logic [2:0]            ring_id;

    int checks = 0;
    int errors = 0;
    int n_cyc;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_item_t;

    sb_item_t sb_q[$];

    multi_alarm_clock #(
        .CLK_HZ     (CLK_HZ),
        .NUM_ALARMS (NUM_ALARMS),
        .RING_S     (RING_S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inc_pulse   (inc_pulse),
        .field_sel   (field_sel),
        .target      (target),
        .alarm_en    (alarm_en),
        .alarm_ack   (alarm_ack),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .disp_hour   (disp_hour),
        .disp_minute (disp_minute),
        .disp_second (disp_second),
        .sec_tick    (sec_tick),
        .ring        (ring),
        .ring_id     (ring_id)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        sb_item_t it;
        it.tag = tag;
        it.val = val;
        sb_q.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            check_value("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            it = sb_q.pop_front();
            check_value(it.tag, obs, it.val);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [31:0] pack_t(input int h, input int m, input int s);
        return {8'h00, bcd(h), bcd(m), bcd(s)};
    endfunction

    function automatic logic [31:0] obs_time();
        return {8'h00, hour, minute, second};
    endfunction

    function automatic logic [31:0] obs_disp();
        return {8'h00, disp_hour, disp_minute, disp_second};
    endfunction

    task automatic cycle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves rst asserted after two edges; the caller releases it.
    task automatic assert_reset(input logic [1:0] fs);
        @(negedge clk);
        rst       = 1'b1;
        inc_pulse = 1'b0;
        alarm_ack = 1'b0;
        field_sel = fs;
        target    = 3'd0;
        cycle(2);
    endtask

    task automatic set_field(input logic [2:0] tgt, input logic [1:0] fs, input int n);
        target    = tgt;
        field_sel = fs;
        inc_pulse = 1'b1;
        cycle(n);
        inc_pulse = 1'b0;
    endtask

    // Returns at the negedge just after the edge that consumed a sec_tick.
    task automatic wait_tick(output int n);
        n = 0;
        while (!sec_tick && n < 4 * CLK_HZ) begin
            @(negedge clk);
            n++;
        end
        check_value("tick_seen", 32'(sec_tick), 32'd1);
        @(negedge clk);
        n++;
    endtask

    task automatic wait_ring();
        int n = 0;
        while (!ring && n < 700) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        inc_pulse = 1'b0;
        field_sel = 2'b00;
        target    = 3'd0;
        alarm_en  = '0;
        alarm_ack = 1'b0;

        // Reset state.
        assert_reset(2'b00);
        sb_push("reset_time", 32'd0);
        sb_push("reset_disp", 32'd0);
        sb_push("reset_misc", 32'd0);
        sb_check(obs_time());
        sb_check(obs_disp());
        sb_check({27'd0, sec_tick, ring, ring_id});

        // Rollover 23:59:58 -> 23:59:59 -> 00:00:00, tick period.
        assert_reset(2'b01);
        rst = 1'b0;
        set_field(3'd0, 2'b01, 23);
        set_field(3'd0, 2'b10, 59);
        set_field(3'd0, 2'b11, 58);
        sb_push("set_235958", pack_t(23, 59, 58));
        sb_check(obs_time());
        field_sel = 2'b00;
        sb_push("roll_235959", pack_t(23, 59, 59));
        sb_push("roll_000000", pack_t(0, 0, 0));
        sb_push("tick_period", 32'(CLK_HZ));
        wait_tick(n_cyc);
        sb_check(obs_time());
        wait_tick(n_cyc);
        sb_check(obs_time());
        sb_check(32'(n_cyc));

        // Minute setting while frozen: no carry, no ticks counted.
        assert_reset(2'b01);
        rst = 1'b0;
        set_field(3'd0, 2'b01, 10);
        set_field(3'd0, 2'b10, 59);
        set_field(3'd0, 2'b11, 30);
        field_sel = 2'b10;
        sb_push("set_minute", pack_t(10, 2, 30));
        sb_push("set_disp", pack_t(10, 2, 30));
        for (int i = 0; i < 3; i++) begin
            inc_pulse = 1'b1;
            cycle(1);
            inc_pulse = 1'b0;
            cycle(12);
        end
        sb_check(obs_time());
        sb_check(obs_disp());

        // Alarm view; second-field set on an alarm and invalid targets are ignored.
        set_field(3'd1, 2'b01, 1);
        set_field(3'd1, 2'b11, 2);
        set_field(3'd5, 2'b01, 2);
        target    = 3'd1;
        field_sel = 2'b00;
        cycle(1);
        sb_push("alarm0_view", pack_t(1, 0, 0));
        sb_check(obs_disp());
        target = 3'd5;
        cycle(1);
        sb_push("invalid_view", 32'd0);
        sb_check(obs_disp());

        // Priority: alarms 1 and 2 at 07:00, lowest index rings.
        assert_reset(2'b00);
        rst      = 1'b0;
        alarm_en = 4'b0110;
        set_field(3'd2, 2'b01, 7);
        set_field(3'd3, 2'b01, 7);
        set_field(3'd0, 2'b01, 6);
        set_field(3'd0, 2'b10, 59);
        field_sel = 2'b00;
        sb_push("prio_time", pack_t(7, 0, 0));
        sb_push("prio_ring", 32'h9);
        sb_push("alarm1_view", pack_t(7, 0, 0));
        sb_push("ring_tick1", 32'd1);
        sb_push("ring_tick2", 32'd1);
        sb_push("ring_tick3", 32'd0);
        wait_ring();
        sb_check(obs_time());
        sb_check({28'd0, ring, ring_id});
        target = 3'd2;
        cycle(1);
        sb_check(obs_disp());
        target = 3'd0;
        for (int i = 0; i < 3; i++) begin
            wait_tick(n_cyc);
            sb_check(32'(ring));
        end

        // Acknowledge stops ringing next cycle; ring_id holds.
        set_field(3'd2, 2'b10, 1);
        target    = 3'd0;
        field_sel = 2'b00;
        sb_push("ack_ring", 32'h9);
        sb_push("ack_stop", 32'h1);
        wait_ring();
        sb_check({28'd0, ring, ring_id});
        alarm_ack = 1'b1;
        cycle(1);
        alarm_ack = 1'b0;
        sb_check({28'd0, ring, ring_id});

        // Dropping the ringing channel's enable stops ringing.
        set_field(3'd2, 2'b10, 1);
        target    = 3'd0;
        field_sel = 2'b00;
        sb_push("dis_ring", 32'h9);
        sb_push("dis_stop", 32'h1);
        wait_ring();
        sb_check({28'd0, ring, ring_id});
        alarm_en = 4'b0100;
        cycle(1);
        sb_check({28'd0, ring, ring_id});
        alarm_en = 4'b0110;

        // Reset mid-ring clears everything; alarm-1 view reads 00:00:00.
        set_field(3'd2, 2'b10, 1);
        target    = 3'd0;
        field_sel = 2'b00;
        sb_push("rst_pre_ring", 32'h9);
        sb_push("rst_time", 32'd0);
        sb_push("rst_disp", 32'd0);
        sb_push("rst_misc", 32'd0);
        sb_push("first_tick", 32'(CLK_HZ - 1));
        wait_ring();
        sb_check({28'd0, ring, ring_id});
        rst    = 1'b1;
        target = 3'd2;
        cycle(1);
        sb_check(obs_time());
        sb_check(obs_disp());
        sb_check({27'd0, sec_tick, ring, ring_id});
        cycle(1);
        rst   = 1'b0;
        // The cycle right after the last reset edge has count 0.
        n_cyc = 0;
        while (!sec_tick && n_cyc < 4 * CLK_HZ) begin
            @(negedge clk);
            n_cyc++;
        end
        sb_check(32'(n_cyc));

        check_value("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
